// File: rtl/alu_selftest_driver.sv
// Self-test sequencer for the 8-bit ALU: applies four fixed vectors and checks
// result/N/Z after ALU_LATENCY cycles, reporting pass, fail count and first failing index.
module alu_selftest_driver #(
    parameter int N           = 8,
    parameter int ALU_LATENCY = 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [N-1:0] alu_out,
    input  logic         alu_flag_n,
    input  logic         alu_flag_z,
    output logic [N-1:0] in_a,
    output logic [N-1:0] in_b,
    output logic [3:0]   operation,
    output logic         busy,
    output logic         done,
    output logic         pass,
    output logic [2:0]   fail_count,
    output logic [1:0]   fail_index
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_APPLY,
        S_WAIT,
        S_DONE
    } state_t;

    state_t       r_state;
    state_t       w_state_nxt;
    logic [1:0]   r_idx;
    logic [3:0]   r_lat;

    logic [1:0]   w_load_idx;
    logic [N-1:0] w_vec_a;
    logic [N-1:0] w_vec_b;
    logic [3:0]   w_vec_op;
    logic [N-1:0] w_exp_out;
    logic         w_exp_n;
    logic         w_exp_z;
    logic         w_start_run;
    logic         w_cmp_now;
    logic         w_last;
    logic         w_mismatch;
    logic         w_load;
    logic [2:0]   w_fail_cnt_nxt;

    // Operand table, indexed by the vector about to be applied
    always_comb begin
        w_vec_a  = '0;
        w_vec_b  = '0;
        w_vec_op = 4'b0000;
        case (w_load_idx)
            2'd0: begin w_vec_a = N'(8'h1A); w_vec_b = N'(8'h2B); w_vec_op = 4'b0000; end
            2'd1: begin w_vec_a = N'(8'h3C); w_vec_b = N'(8'h1F); w_vec_op = 4'b0001; end
            2'd2: begin w_vec_a = N'(8'hFF); w_vec_b = N'(8'h0F); w_vec_op = 4'b0010; end
            default: begin w_vec_a = N'(8'hAA); w_vec_b = N'(8'h55); w_vec_op = 4'b0011; end
        endcase
    end

    // Expected response table, indexed by the vector currently under test
    always_comb begin
        w_exp_out = '0;
        w_exp_n   = 1'b0;
        w_exp_z   = 1'b0;
        case (r_idx)
            2'd0: w_exp_out = N'(8'h45);
            2'd1: w_exp_out = N'(8'h1D);
            2'd2: w_exp_out = N'(8'h0F);
            default: begin w_exp_out = N'(8'hFF); w_exp_n = 1'b1; end
        endcase
    end

    assign w_start_run    = start && ((r_state == S_IDLE) || (r_state == S_DONE));
    assign w_cmp_now      = (r_state == S_WAIT) && (r_lat == 4'd0);
    assign w_last         = (r_idx == 2'd3);
    assign w_mismatch     = w_cmp_now &&
                            ({alu_out, alu_flag_n, alu_flag_z} != {w_exp_out, w_exp_n, w_exp_z});
    assign w_load         = w_start_run || (w_cmp_now && !w_last);
    assign w_load_idx     = (r_state == S_WAIT) ? r_idx + 2'd1 : 2'd0;
    assign w_fail_cnt_nxt = fail_count + {2'b00, w_mismatch};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (start) w_state_nxt = S_APPLY;
            S_APPLY: w_state_nxt = S_WAIT;
            S_WAIT:  if (r_lat == 4'd0) w_state_nxt = w_last ? S_DONE : S_APPLY;
            S_DONE:  if (start) w_state_nxt = S_APPLY;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_idx      <= 2'd0;
            r_lat      <= 4'd0;
            in_a       <= '0;
            in_b       <= '0;
            operation  <= 4'b0000;
            busy       <= 1'b0;
            done       <= 1'b0;
            pass       <= 1'b0;
            fail_count <= 3'd0;
            fail_index <= 2'd0;
        end else begin
            if (w_start_run) begin
                r_idx      <= 2'd0;
                fail_count <= 3'd0;
                fail_index <= 2'd0;
                pass       <= 1'b0;
                done       <= 1'b0;
                busy       <= 1'b1;
            end

            if (w_load) begin
                in_a      <= w_vec_a;
                in_b      <= w_vec_b;
                operation <= w_vec_op;
            end

            if (r_state == S_APPLY) begin
                r_lat <= 4'(ALU_LATENCY - 1);
            end else if ((r_state == S_WAIT) && (r_lat != 4'd0)) begin
                r_lat <= r_lat - 4'd1;
            end

            // Final verdict folds in the last vector's compare from this same edge
            if (w_cmp_now) begin
                if (w_mismatch) begin
                    fail_count <= w_fail_cnt_nxt;
                    if (fail_count == 3'd0) fail_index <= r_idx;
                end
                if (w_last) begin
                    busy <= 1'b0;
                    done <= 1'b1;
                    pass <= (w_fail_cnt_nxt == 3'd0);
                end else begin
                    r_idx <= r_idx + 2'd1;
                end
            end
        end
    end

endmodule

// File: doc/alu_selftest_driver.md
Name: alu_selftest_driver

Overview:
- On-chip stimulus/checker for the 8-bit ALU measurement circuit; the hardware counterpart of the bench that drives the ALU.
- On `start`, applies a fixed table of four operand/opcode vectors to the ALU inputs, one at a time.
- Samples the ALU result and N/Z flags after a programmable latency and compares them against stored expected values.
- Reports pass/fail, failure count and first failing vector index; used for board-level self-test ahead of the seven-segment display path.

Parameters:
- N, 8, operand/result width; the vector table is defined for N=8 only.
- ALU_LATENCY, 1, cycles from vector applied to result valid; legal range 1..15.

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous active-high reset
- start  input  1  single-cycle run request
- alu_out  input  N  ALU result
- alu_flag_n  input  1  ALU negative flag
- alu_flag_z  input  1  ALU zero flag
- in_a  output  N  operand A to ALU (registered)
- in_b  output  N  operand B to ALU (registered)
- operation  output  4  ALU opcode (registered)
- busy  output  1  run in progress
- done  output  1  run finished; held until the next run starts
- pass  output  1  valid while done=1; 1 = all vectors matched
- fail_count  output  3  number of mismatching vectors, 0..4
- fail_index  output  2  index of the first failing vector; 0 if none

Behaviour:
- Reset (asynchronous, active-high), effective immediately, including mid-run:
  - State = IDLE.
  - in_a, in_b, operation, busy, done, pass, fail_count, fail_index all 0.
  - Vector index = 0; latency counter = 0.
- Vector table, fixed (index: a, b, op -> expected out, N, Z):
  - 0: 8'h1A, 8'h2B, 4'b0000 (add) -> 8'h45, N=0, Z=0
  - 1: 8'h3C, 8'h1F, 4'b0001 (sub) -> 8'h1D, N=0, Z=0
  - 2: 8'hFF, 8'h0F, 4'b0010 (and) -> 8'h0F, N=0, Z=0
  - 3: 8'hAA, 8'h55, 4'b0011 (or) -> 8'hFF, N=1, Z=0
  - C and V flags are not checked.
- States: IDLE, APPLY, WAIT, DONE.
- IDLE:
  - start=1 -> APPLY.
  - On that edge: index=0, fail_count=0, fail_index=0, pass=0, done=0, busy=1.
- APPLY (1 cycle):
  - in_a/in_b/operation take table[index] on the edge entering APPLY; valid from the APPLY cycle onward.
  - Latency counter loads ALU_LATENCY-1 -> WAIT.
- WAIT (ALU_LATENCY cycles):
  - Counter decrements each cycle.
  - At the edge ending the cycle where counter==0, compare {alu_out, alu_flag_n, alu_flag_z} against expected.
  - On mismatch: fail_count++; if it was the first mismatch, fail_index=index.
  - Then, if index==3 -> DONE; else index++ -> APPLY.
- Timing: run length = 4*(1+ALU_LATENCY) cycles, from the edge that accepts start to the edge entering DONE.
- DONE:
  - busy=0, done=1.
  - pass=1 iff fail_count==0; pass is evaluated including the final vector's compare.
  - in_a/in_b/operation hold the last vector.
  - start=1 restarts exactly as from IDLE; done drops on the restart edge.
- start while busy=1 is ignored; it neither restarts nor extends the run.
- fail_count saturates naturally at 4 (3-bit field, max 4 vectors).
- Operand outputs never change during WAIT. Only reset or the next APPLY edge changes them.

Test Plan:
- ALU_LATENCY=1, ideal ALU model, start pulse -> busy for 8 cycles; done=1, pass=1, fail_count=0, fail_index=0; operation sequence 0,1,2,3 observed.
- Model faulted to return 8'h44 for add -> done=1, pass=0, fail_count=1, fail_index=0.
- Model forces N=0 on OR and returns 8'h0E on AND -> fail_count=2, fail_index=2, pass=0.
- ALU_LATENCY=3, model delays the result 3 cycles -> pass=1, done asserted 16 cycles after start; with a 4-cycle model delay -> pass=0.
- start re-pulsed during vector 1, then reset asserted during vector 2 WAIT -> start ignored; all outputs 0 immediately on reset; subsequent start gives a full clean pass run.
- Second start while in DONE -> done drops next edge, counters cleared, run repeats with identical results.
